logic_result_pipe: RTL and testbench

LOGIC_RESULT_PIPE -- requirements
Module: logic_result_pipe

---
 rtl/logic_result_pipe.sv | 98 +++++++++
 tb/tb_logic_result_pipe.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_result_pipe.sv
// Two-entry result FIFO: captures the op-selected gate result with its zero and
// illegal-op flags, then delivers entries in order and counts pops.
module logic_result_pipe (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [2:0] op,
    input  logic [3:0] y1,
    input  logic [3:0] y2,
    input  logic [3:0] y3,
    input  logic [3:0] y4,
    input  logic [3:0] y5,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] result,
    output logic       zero,
    output logic       bad_op,
    output logic [7:0] txn_count
);

    logic [1:0] count_reg;
    logic [1:0] count_next;
    logic       wr_ptr_reg;
    logic       rd_ptr_reg;
    logic [7:0] txn_count_reg;
    logic [5:0] capture_next;
    logic [5:0] head;
    logic       push;
    logic       pop;

    // Entry layout is {bad_op, zero, result}; zero is fixed at capture time.
    always_comb begin
        capture_next = 6'b11_0000;
        case (op)
            3'd0:    capture_next = {1'b0, y1 == 4'b0000, y1};
            3'd1:    capture_next = {1'b0, y2 == 4'b0000, y2};
            3'd2:    capture_next = {1'b0, y3 == 4'b0000, y3};
            3'd3:    capture_next = {1'b0, y4 == 4'b0000, y4};
            3'd4:    capture_next = {1'b0, y5 == 4'b0000, y5};
            default: capture_next = 6'b11_0000;
        endcase
    end

    // in_ready depends only on registered occupancy and reset, never on out_ready.
    assign in_ready  = !reset && (count_reg < 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            logic [5:0] slot_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    slot_reg <= '0;
                end else if (push && (wr_ptr_reg == 1'(gi))) begin
                    slot_reg <= capture_next;
                end
            end
        end
    endgenerate

    assign head = rd_ptr_reg ? g_slot[1].slot_reg : g_slot[0].slot_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg     <= 2'd0;
            wr_ptr_reg    <= 1'b0;
            rd_ptr_reg    <= 1'b0;
            txn_count_reg <= 8'd0;
        end else begin
            count_reg <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg    <= ~rd_ptr_reg;
                txn_count_reg <= txn_count_reg + 8'd1;
            end
        end
    end

    assign result    = out_valid ? head[3:0] : 4'b0000;
    assign zero      = out_valid ? head[4]   : 1'b0;
    assign bad_op    = out_valid ? head[5]   : 1'b0;
    assign txn_count = txn_count_reg;

endmodule

// File: tb/tb_logic_result_pipe.sv
// Randomized and directed checks of logic_result_pipe against a queue-based model.
module tb_logic_result_pipe;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] op = 3'd0;
    logic [3:0] y1 = 4'd0, y2 = 4'd0, y3 = 4'd0, y4 = 4'd0, y5 = 4'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] result;
    logic       zero;
    logic       bad_op;
    logic [7:0] txn_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Model: queue of {bad_op, zero, result}, pop counter kept as plain integer.
    logic [5:0] model_q[$];
    int         model_txn = 0;

    logic_result_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .y1(y1), .y2(y2), .y3(y3), .y4(y4), .y5(y5),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .bad_op(bad_op), .txn_count(txn_count)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] model_entry(input logic [2:0] o, input logic [3:0] ys [5]);
        int v;
        if (o <= 3'd4) begin
            v = ys[o];
            return {1'b0, (v == 0), 4'(v)};
        end
        return {1'b1, 1'b1, 4'b0000};
    endfunction

    function automatic logic [15:0] expected_vec();
        logic [5:0] h;
        logic       ir;
        h  = (model_q.size() > 0) ? model_q[0] : 6'b0;
        ir = !reset && (model_q.size() < 2);
        return {ir, model_q.size() > 0, h[3:0], h[4], h[5], 8'(model_txn % 256)};
    endfunction

    function automatic logic [15:0] observed_vec();
        return {in_ready, out_valid, result, zero, bad_op, txn_count};
    endfunction

    // Drive one cycle of inputs, advance through the rising edge, update the model.
    task automatic step(input logic rst, input logic iv, input logic [2:0] o,
                        input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic [3:0] e, input logic ordy);
        logic       do_push;
        logic       do_pop;
        logic [3:0] ys [5];
        reset = rst; in_valid = iv; op = o; out_ready = ordy;
        y1 = a; y2 = b; y3 = c; y4 = d; y5 = e;
        ys[0] = a; ys[1] = b; ys[2] = c; ys[3] = d; ys[4] = e;
        do_push = !rst && iv && (model_q.size() < 2);
        do_pop  = !rst && ordy && (model_q.size() > 0);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
            model_txn = 0;
        end else begin
            if (do_pop) begin
                void'(model_q.pop_front());
                model_txn = (model_txn + 1) % 256;
            end
            if (do_push) model_q.push_back(model_entry(o, ys));
        end
        #1;
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, 3'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, ordy);
    endtask

    task automatic test_reset();
        step(1'b1, 1'b1, 3'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
        step(1'b1, 1'b1, 3'd0, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b1);
        tests_run++;
        if ({in_ready, out_valid, result, zero, bad_op, txn_count} !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_hold: got %h expected 0000", observed_vec());
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        #1;
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid);
        end
        $display("[TB] reset: done");
    endtask

    task automatic test_single_push();
        int base;
        base = model_txn;
        step(1'b0, 1'b1, 3'd2, 4'h0, 4'h0, 4'b0110, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 4'b0110 || zero !== 1'b0 || bad_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_push: v=%b r=%b z=%b b=%b expected 1 0110 0 0", out_valid, result, zero, bad_op);
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b0 || txn_count !== 8'(base + 1)) begin
            tests_failed++;
            $display("FAIL single_pop: v=%b txn=%0d expected 0 %0d", out_valid, txn_count, base + 1);
        end
        $display("[TB] single_push: result=%b txn=%0d", 4'b0110, txn_count);
    endtask

    task automatic test_fill_backpressure();
        int base;
        base = model_txn;
        step(1'b0, 1'b1, 3'd0, 4'b1010, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 3'd4, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0000, 1'b0);
        tests_run++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || result !== 4'b1010) begin
            tests_failed++;
            $display("FAIL fill_full: ir=%b v=%b r=%b expected 0 1 1010", in_ready, out_valid, result);
        end
        step(1'b0, 1'b1, 3'd1, 4'h0, 4'b1111, 4'h0, 4'h0, 4'h0, 1'b0);
        tests_run++;
        if (result !== 4'b1010 || in_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_ignored: r=%b ir=%b expected 1010 0", result, in_ready);
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 4'b0000 || zero !== 1'b1 || bad_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL fill_second: v=%b r=%b z=%b b=%b expected 1 0000 1 0", out_valid, result, zero, bad_op);
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b0 || txn_count !== 8'(base + 2)) begin
            tests_failed++;
            $display("FAIL fill_drain: v=%b txn=%0d expected 0 %0d", out_valid, txn_count, base + 2);
        end
        $display("[TB] fill_backpressure: txn=%0d", txn_count);
    endtask

    task automatic test_illegal_op();
        step(1'b0, 1'b1, 3'd6, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 1'b0);
        tests_run++;
        if (result !== 4'b0000 || zero !== 1'b1 || bad_op !== 1'b1 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL illegal_op: r=%b z=%b b=%b v=%b expected 0000 1 1 1", result, zero, bad_op, out_valid);
        end
        idle(1'b1);
        $display("[TB] illegal_op: op=6 captured");
    endtask

    task automatic test_simultaneous();
        step(1'b0, 1'b1, 3'd0, 4'b0011, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 3'd1, 4'h0, 4'b1100, 4'h0, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b1 || result !== 4'b1100 || in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL simul_push_pop: v=%b r=%b ir=%b expected 1 1100 1", out_valid, result, in_ready);
        end
        idle(1'b1);
        // Full FIFO with push and pop presented together: push ignored, count drops to 1.
        step(1'b0, 1'b1, 3'd3, 4'h0, 4'h0, 4'h0, 4'b0101, 4'h0, 1'b0);
        step(1'b0, 1'b1, 3'd2, 4'h0, 4'h0, 4'b1001, 4'h0, 4'h0, 1'b0);
        step(1'b0, 1'b1, 3'd0, 4'b0111, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if (result !== 4'b1001 || in_ready !== 1'b1 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL full_pop: r=%b ir=%b v=%b expected 1001 1 1", result, in_ready, out_valid);
        end
        idle(1'b1);
        tests_run++;
        if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL full_pop_drain: v=%b expected 0", out_valid);
        end
        $display("[TB] simultaneous: done");
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                 1'($urandom_range(0, 2) != 0));
            tests_run++;
            if (observed_vec() !== expected_vec()) begin
                tests_failed++;
                $display("FAIL random[%0d]: got %h expected %h", i, observed_vec(), expected_vec());
            end
        end
        $display("[TB] random: 400 cycles, txn=%0d", txn_count);
    endtask

    task automatic test_wrap_and_reset();
        step(1'b1, 1'b0, 3'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 257; i++) begin
            step(1'b0, 1'b1, 3'($urandom_range(0, 4)), 4'($urandom), 4'($urandom),
                 4'($urandom), 4'($urandom), 4'($urandom), 1'b1);
        end
        tests_run++;
        if (txn_count !== 8'd0 || out_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap: txn=%0d v=%b expected 0 1", txn_count, out_valid);
        end
        step(1'b0, 1'b1, 3'd1, 4'h0, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0);
        tests_run++;
        if (in_ready !== 1'b0 || observed_vec() !== expected_vec()) begin
            tests_failed++;
            $display("FAIL wrap_full: got %h expected %h", observed_vec(), expected_vec());
        end
        step(1'b1, 1'b1, 3'd0, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1);
        tests_run++;
        if (out_valid !== 1'b0 || txn_count !== 8'd0 || result !== 4'b0000 || zero !== 1'b0 || bad_op !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: v=%b txn=%0d r=%b z=%b b=%b expected 0 0 0000 0 0",
                     out_valid, txn_count, result, zero, bad_op);
        end
        idle(1'b1);
        tests_run++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || txn_count !== 8'd0) begin
            tests_failed++;
            $display("FAIL post_reset: ir=%b v=%b txn=%0d expected 1 0 0", in_ready, out_valid, txn_count);
        end
        $display("[TB] wrap_and_reset: txn=%0d", txn_count);
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill_backpressure();
        test_illegal_op();
        test_simultaneous();
        test_random();
        test_wrap_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
